// File: rtl/rf_pkg.sv
// Shared register-file constants and select type.
// Used by decode, writeback and the register file itself.
package rf_pkg;

  localparam int RF_WIDTH = 20;
  localparam int RF_DEPTH = 16;
  localparam int RF_AW    = $clog2(RF_DEPTH);

  typedef logic [RF_AW-1:0] rf_sel_t;

endpackage

// File: rtl/register_file_sb_if.sv
// Decode/writeback bus into the scoreboarded register file.
// Master is the pipeline side, slave is the register file.
interface register_file_sb_if
  import rf_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH
);

  localparam int AW = $clog2(DEPTH);

  logic             w;
  logic [AW-1:0]    w_select;
  logic [WIDTH-1:0] write;
  logic [AW-1:0]    r1_select;
  logic [AW-1:0]    r2_select;
  logic [WIDTH-1:0] read1;
  logic [WIDTH-1:0] read2;
  logic             r1_ready;
  logic             r2_ready;
  logic             claim;
  logic [AW-1:0]    claim_select;
  logic             claim_ok;
  logic [AW:0]      pending;

  modport master (
    output w, w_select, write,
    output r1_select, r2_select,
    output claim, claim_select,
    input  read1, read2,
    input  r1_ready, r2_ready,
    input  claim_ok, pending
  );

  modport slave (
    input  w, w_select, write,
    input  r1_select, r2_select,
    input  claim, claim_select,
    output read1, read2,
    output r1_ready, r2_ready,
    output claim_ok, pending
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits, claim acceptance, operand
// readiness and the registered count of busy registers.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int DEPTH    = RF_DEPTH,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          w,
  input  logic [AW-1:0] w_select,
  input  logic [AW-1:0] r1_select,
  input  logic [AW-1:0] r2_select,
  input  logic          claim,
  input  logic [AW-1:0] claim_select,
  output logic          r1_ready,
  output logic          r2_ready,
  output logic          claim_ok,
  output logic [AW:0]   pending
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      pending_q, pending_d;

  logic wb_en;
  logic w_zero, c_zero, r1_zero, r2_zero;
  logic set_en, clr_en, inc, dec;

  always_comb begin
    wb_en   = w & rst_n;
    w_zero  = (ZERO_REG != 0) && (w_select == '0);
    c_zero  = (ZERO_REG != 0) && (claim_select == '0);
    r1_zero = (ZERO_REG != 0) && (r1_select == '0);
    r2_zero = (ZERO_REG != 0) && (r2_select == '0);

    r1_ready = r1_zero | ~busy_q[r1_select]
             | (wb_en & (w_select == r1_select));
    r2_ready = r2_zero | ~busy_q[r2_select]
             | (wb_en & (w_select == r2_select));

    claim_ok = claim & (c_zero
             | ~busy_q[claim_select]
             | (wb_en & (w_select == claim_select)));

    set_en = claim_ok & ~c_zero;
    clr_en = wb_en & ~w_zero;

    // A same-cycle claim wins over the writeback clear.
    busy_d = busy_q;
    if (clr_en) busy_d[w_select] = 1'b0;
    if (set_en) busy_d[claim_select] = 1'b1;

    inc = set_en & ~busy_q[claim_select];
    dec = clr_en & busy_q[w_select]
        & ~(set_en & (claim_select == w_select));

    pending_d = pending_q;
    if (inc && !dec)
      pending_d = pending_q + (AW+1)'(1);
    else if (dec && !inc)
      pending_d = pending_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/register_file_sb.sv
// Parametrised register file with optional zero register,
// write-to-read bypass and a pending-write scoreboard.
module register_file_sb
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ZERO_REG = 0
) (
  input logic clk,
  input logic reset,
  register_file_sb_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  logic             we;
  logic [WIDTH-1:0] rd1, rd2;

  // Gating with reset keeps reads at zero while reset is held.
  always_comb begin
    we = bus.w & reset
       & ~((ZERO_REG != 0) && (bus.w_select == '0));
    regs_d = regs_q;
    if (we) regs_d[bus.w_select] = bus.write;
  end

  always_comb begin
    rd1 = regs_q[bus.r1_select];
    if (we && (bus.w_select == bus.r1_select))
      rd1 = bus.write;
    if ((ZERO_REG != 0) && (bus.r1_select == '0))
      rd1 = '0;

    rd2 = regs_q[bus.r2_select];
    if (we && (bus.w_select == bus.r2_select))
      rd2 = bus.write;
    if ((ZERO_REG != 0) && (bus.r2_select == '0))
      rd2 = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign bus.read1 = rd1;
  assign bus.read2 = rd2;

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk          (clk),
    .rst_n        (reset),
    .w            (bus.w),
    .w_select     (bus.w_select[AW-1:0]),
    .r1_select    (bus.r1_select[AW-1:0]),
    .r2_select    (bus.r2_select[AW-1:0]),
    .claim        (bus.claim),
    .claim_select (bus.claim_select[AW-1:0]),
    .r1_ready     (bus.r1_ready),
    .r2_ready     (bus.r2_ready),
    .claim_ok     (bus.claim_ok),
    .pending      (bus.pending)
  );

endmodule
